// File: rtl/prog_loader.sv
// Boot loader: packs a byte stream (N, N x {B0,B1,B2}, C) into 18-bit words for the instruction store.
// Latency: write strobe 1 cycle after the B2 accept; cpu_run 1 cycle after the checksum accept.
// Backpressure: in_ready is high in every frame state (1 byte/cycle), low in RUN/ERROR and in reset.
module prog_loader #(
  parameter int AW = 4,
  parameter int IW = 18
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          cpu_run,
  output logic          busy,
  output logic          error
);

  localparam int MAXN = 1 << AW;

  typedef enum logic [2:0] {
    S_COUNT,
    S_B0,
    S_B1,
    S_B2,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          r_state;
  logic [AW:0]     r_n;
  logic [AW:0]     r_wcnt;
  logic [7:0]      r_csum;
  logic [7:0]      r_b0;
  logic [7:0]      r_b1;
  logic            r_wr_en;
  logic [IW-1:0]   r_wr_data;
  logic            r_cpu_run;
  logic            r_busy;
  logic            r_error;

  logic            w_rdy;
  logic            w_acc;
  logic            w_n_bad;
  logic            w_last_word;

  // Byte acceptance: only in frame states and never while reset is asserted.
  always_comb begin
    w_rdy = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_COUNT, S_B0, S_B1, S_B2, S_CHECK: w_rdy = 1'b1;
        default:                            w_rdy = 1'b0;
      endcase
    end
  end

  assign w_acc       = in_valid & w_rdy;
  // Header must name 1..2**AW words.
  assign w_n_bad     = (in_data == 8'd0) || ({24'd0, in_data} > 32'(MAXN));
  // The counter still holds the index of the word being completed.
  assign w_last_word = ((r_wcnt + 1'b1) == r_n);

  // Frame FSM, packing, checksum and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_COUNT;
      r_n       <= '0;
      r_wcnt    <= '0;
      r_csum    <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_cpu_run <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // Address advances once the write pulse has been presented.
      if (r_wr_en) r_wcnt <= r_wcnt + 1'b1;
      case (r_state)
        S_COUNT: begin
          if (w_acc) begin
            r_csum <= r_csum ^ in_data;
            if (w_n_bad) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end else begin
              r_n     <= in_data[AW:0];
              r_wcnt  <= '0;
              r_busy  <= 1'b1;
              r_state <= S_B0;
            end
          end
        end
        S_B0: begin
          if (w_acc) begin
            r_csum  <= r_csum ^ in_data;
            r_b0    <= in_data;
            r_state <= S_B1;
          end
        end
        S_B1: begin
          if (w_acc) begin
            r_csum  <= r_csum ^ in_data;
            r_b1    <= in_data;
            r_state <= S_B2;
          end
        end
        S_B2: begin
          if (w_acc) begin
            r_csum <= r_csum ^ in_data;
            if (in_data[7:2] != 6'd0) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_data <= {in_data[1:0], r_b1, r_b0};
              r_state   <= w_last_word ? S_CHECK : S_B0;
            end
          end
        end
        S_CHECK: begin
          if (w_acc) begin
            r_busy <= 1'b0;
            if (in_data == r_csum) begin
              r_state   <= S_RUN;
              r_cpu_run <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        S_RUN, S_ERROR: begin
          if (reload) begin
            r_state   <= S_COUNT;
            r_cpu_run <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
            r_csum    <= '0;
            r_wcnt    <= '0;
          end
        end
        default: r_state <= S_COUNT;
      endcase
    end
  end

  assign in_ready = w_rdy;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wcnt[AW-1:0];
  assign wr_data  = r_wr_data;
  assign cpu_run  = r_cpu_run;
  assign busy     = r_busy;
  assign error    = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, error paths, reload and mid-load reset.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
// Writes to the instruction store are logged by a falling-edge monitor.
module tb_prog_loader;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        reload;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [17:0] wr_data;
  logic        cpu_run;
  logic        busy;
  logic        error;

  int n_vec;
  int n_err;

  logic [3:0]  wlog_addr [256];
  logic [17:0] wlog_data [256];
  int          wlog_n;

  prog_loader #(.AW(4), .IW(18)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .reload   (reload),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every instruction-memory write strobe.
  initial wlog_n = 0;
  always @(negedge clk) begin
    if (wr_en && wlog_n < 256) begin
      wlog_addr[wlog_n] = wr_addr;
      wlog_data[wlog_n] = wr_data;
      wlog_n = wlog_n + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte after `gap` idle cycles; returns on the falling edge after it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
    check_val({tag, "_wr_addr"},  {28'd0, wr_addr},  32'd0);
    check_val({tag, "_wr_data"},  {14'd0, wr_data},  32'd0);
    check_val({tag, "_cpu_run"},  {31'd0, cpu_run},  32'd0);
    check_val({tag, "_busy"},     {31'd0, busy},     32'd0);
    check_val({tag, "_error"},    {31'd0, error},    32'd0);
    check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    int base;
    n_vec    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;

    // ---- reset state
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_val("count_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("count_busy",     {31'd0, busy},     32'd0);

    // ---- good 1-word load: 01 13 00 02 10 -> 18'h20013 at addr 0
    base = wlog_n;
    send_byte(8'h01, 0);
    check_val("hdr_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    check_val("w1_wr_en",   {31'd0, wr_en},   32'd1);
    check_val("w1_wr_addr", {28'd0, wr_addr}, 32'd0);
    check_val("w1_wr_data", {14'd0, wr_data}, 32'h20013);
    send_byte(8'h10, 0);
    check_val("w1_cpu_run",  {31'd0, cpu_run},  32'd1);
    check_val("w1_busy",     {31'd0, busy},     32'd0);
    check_val("w1_error",    {31'd0, error},    32'd0);
    check_val("w1_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("w1_nwrites",  wlog_n - base,     32'd1);

    // ---- reload together with a byte in RUN: reload wins, byte not consumed
    in_valid = 1'b1;
    in_data  = 8'h05;
    pulse_reload();
    in_valid = 1'b0;
    check_val("rl_run_cpu_run",  {31'd0, cpu_run},  32'd0);
    check_val("rl_run_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rl_run_busy",     {31'd0, busy},     32'd0);

    // ---- bad checksum: write still happens, then ERROR
    base = wlog_n;
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    check_val("bc_nwrites",  wlog_n - base,     32'd1);
    check_val("bc_error",    {31'd0, error},    32'd1);
    check_val("bc_cpu_run",  {31'd0, cpu_run},  32'd0);
    check_val("bc_in_ready", {31'd0, in_ready}, 32'd0);
    // byte offered in ERROR is ignored
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bc_err_hold", {31'd0, error}, 32'd1);
    check_val("bc_err_busy", {31'd0, busy},  32'd0);
    pulse_reload();
    check_val("bc_rl_error",    {31'd0, error},    32'd0);
    check_val("bc_rl_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- illegal B2 (06 has bit 2 set)
    base = wlog_n;
    send_byte(8'h01, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h06, 0);
    check_val("ib_error",   {31'd0, error}, 32'd1);
    check_val("ib_wr_en",   {31'd0, wr_en}, 32'd0);
    check_val("ib_nwrites", wlog_n - base,  32'd0);
    pulse_reload();

    // ---- full 16-word image with in_valid bubbles; word k = 18'h3FF00 + k
    base = wlog_n;
    send_byte(8'h10, 1);
    for (int k = 0; k < 16; k++) begin
      send_byte(8'(k),  (k * 7) % 3);
      send_byte(8'hFF,  k % 2);
      send_byte(8'h03,  (k + 1) % 3);
    end
    // XOR of header 10, sixteen FF, sixteen 03 and 0..15 is 10.
    send_byte(8'h10, 2);
    check_val("full_nwrites", wlog_n - base, 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_val($sformatf("full_addr%0d", k), {28'd0, wlog_addr[base + k]}, 32'(k));
      check_val($sformatf("full_data%0d", k), {14'd0, wlog_data[base + k]}, 32'h3FF00 + 32'(k));
    end
    check_val("full_cpu_run", {31'd0, cpu_run}, 32'd1);
    check_val("full_error",   {31'd0, error},   32'd0);
    pulse_reload();

    // ---- bad headers: 00 and 11 (17 > 16)
    base = wlog_n;
    send_byte(8'h00, 0);
    check_val("h00_error", {31'd0, error}, 32'd1);
    check_val("h00_busy",  {31'd0, busy},  32'd0);
    pulse_reload();
    send_byte(8'h11, 0);
    check_val("h11_error", {31'd0, error}, 32'd1);
    check_val("hdr_nwrites", wlog_n - base, 32'd0);
    pulse_reload();

    // ---- reset mid-load, after B1 of the third word
    base = wlog_n;
    send_byte(8'h03, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'h01, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("mid_nwrites", wlog_n - base, 32'd2);
    check_val("mid_addr1",   {28'd0, wlog_addr[base + 1]}, 32'd1);
    check_val("mid_data1",   {14'd0, wlog_data[base + 1]}, 32'h11234);
    base = wlog_n;
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    check_val("post_wr_addr", {28'd0, wr_addr}, 32'd0);
    check_val("post_wr_data", {14'd0, wr_data}, 32'h20013);
    send_byte(8'h10, 0);
    check_val("post_cpu_run", {31'd0, cpu_run}, 32'd1);
    check_val("post_nwrites", wlog_n - base,    32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the CPU instruction memory, which the CPU only reads (18-bit words, 4-bit PC address).
- Accepts a byte stream over a valid/ready handshake and packs every 3 bytes into one 18-bit instruction.
- Writes the instructions sequentially into the instruction store, checks a trailing XOR checksum, then releases the CPU.
- Sits between the board I/O (host byte source) and the CPU/instruction-memory pair; holds the CPU stalled until a good image is loaded.

Parameters:
- AW, 4, instruction address width; the image holds 1..2**AW words.
- IW, 18, instruction width; fixed at 18, since the byte packing below assumes it.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- in_valid  in  1  byte source has data.
- in_data  in  8  byte payload.
- in_ready  out  1  loader accepts a byte; transfer happens when in_valid & in_ready.
- reload  in  1  restart the load from RUN or ERROR.
- wr_en  out  1  instruction-memory write strobe, one cycle.
- wr_addr  out  AW  write address.
- wr_data  out  IW  write data.
- cpu_run  out  1  1 = CPU may run, 0 = CPU held.
- busy  out  1  load in progress.
- error  out  1  sticky error flag, cleared by reload or reset.

Behaviour:
- Reset (reset_n=0 at an edge): state=COUNT, wr_addr=0, word counter=0, checksum=0, byte staging=0. Outputs: wr_en=0, wr_data=0, cpu_run=0, busy=0, error=0, in_ready=0 (in_ready is forced 0 while reset_n=0).
- Reset mid-load aborts with no further wr_en. Words already written stay in memory.
- Frame: header N (word count), then N x {B0, B1, B2}, then checksum C.
- Packing: word = {B2[1:0], B1, B0}. B2[7:2] must be 0.
- Checksum rule: C must equal the XOR of the header and every data byte.
- in_ready=1 in COUNT, B0, B1, B2, CHECK; 0 in RUN and ERROR. The loader never stalls mid-frame, so throughput is 1 byte/cycle. A byte with in_valid=0 is not consumed; the state holds.
- Every accepted byte is XORed into the checksum, except C itself.
- COUNT: on accept, if N==0 or N>2**AW go to ERROR. Else store N, word counter=0, busy=1, go to B0.
- B0 -> B1 -> B2: each byte is latched on accept.
- B2 accept with B2[7:2]!=0: go to ERROR, no write.
- B2 accept, otherwise: next cycle wr_en=1, wr_data=packed word, wr_addr=word counter. wr_addr then increments after the write pulse. Counter wrap at 2**AW is unreachable because N is bounded.
- After B2, if the word counter after increment equals N go to CHECK, else go to B0.
- CHECK accept: if C==checksum go to RUN (cpu_run=1, busy=0 from the next cycle); else go to ERROR.
- ERROR: error=1, busy=0, cpu_run=0; incoming bytes are ignored (in_ready=0).
- RUN: cpu_run stays 1; in_ready=0.
- reload=1 in RUN or ERROR: next cycle go to COUNT; cpu_run=0, error=0, checksum=0, wr_addr=0, busy=0 until the header is accepted.
- reload in any other state is ignored.
- reset_n has priority over reload.
- Simultaneous reload and in_valid in RUN: reload wins, and the byte is not consumed (in_ready was 0).
- Latency: the final wr_en occurs one cycle after the last B2 accept. cpu_run rises one cycle after the C accept.
- Unused bits of wr_data are not applicable; IW=18 is fully driven.

Test Plan:
- Good 1-word load: bytes 01,13,00,02,10 back-to-back -> one wr_en with wr_addr=0, wr_data=18'h20013; cpu_run=1 one cycle after 0x10 is accepted; error=0.
- Bad checksum: 01,13,00,02,11 -> wr at addr 0 still occurs; error=1, cpu_run=0, in_ready=0; then reload=1 -> COUNT, error=0, in_ready=1.
- Illegal B2: 01,FF,FF,06 -> no wr_en, error=1 on the cycle after 0x06 is accepted.
- Full image with in_valid gaps: header 10 (16 words) with word k = 18'h3_FF00 + k, random in_valid bubbles -> 16 writes to addresses 0..15 in order with correct data; correct XOR -> cpu_run=1.
- Bad header: header 00 -> ERROR; header 11 (17 words > 2**AW) with AW=4 -> ERROR; no wr_en in either case.
- Reset mid-load: reset_n=0 after B1 of word 2 -> no wr_en; all outputs 0 on the cycle after reset; the next frame 01,13,00,02,10 loads to addr 0.
